// File: rtl/gps_sample_packer_if.sv
// Bus bundle for gps_sample_packer: strobe/sample input, valid/ready word output,
// overflow status, and the fill counter exposed for observation.
interface gps_sample_packer_if #(
  parameter int BITS_PER_SAMPLE = 2,
  parameter int WORD_WIDTH      = 16
);
  localparam int SAMPLES_PER_WORD = WORD_WIDTH / BITS_PER_SAMPLE;
  localparam int FILL_W = (SAMPLES_PER_WORD > 1) ? $clog2(SAMPLES_PER_WORD) : 1;

  // Output handshake: a word moves on any cycle where word_valid and word_ready
  // are both 1; word is stable while word_valid is 1 and word_valid never drops
  // without a transfer. word_ready while word_valid is 0 has no effect.
  logic                       strobe;
  logic [BITS_PER_SAMPLE-1:0] sample;
  logic [WORD_WIDTH-1:0]      word;
  logic                       word_valid;
  logic                       word_ready;
  logic                       overflow;
  logic                       clear_ovf;
  logic [7:0]                 drop_count;
  logic [FILL_W-1:0]          fill;

  // master: the packer itself
  modport master (
    input  strobe, sample, word_ready, clear_ovf,
    output word, word_valid, overflow, drop_count, fill
  );

  // slave: upstream edge detector plus downstream host
  modport slave (
    output strobe, sample, word_ready, clear_ovf,
    input  word, word_valid, overflow, drop_count, fill
  );
endinterface

// File: rtl/gps_sample_packer.sv
// Shifts strobed GPS samples into words (first sample in the MSBs) and offers them
// through a one-word holding register; words completing while it is occupied are dropped.
module gps_sample_packer #(
  parameter int BITS_PER_SAMPLE = 2,
  parameter int WORD_WIDTH      = 16
) (
  input logic               clk,
  input logic               rst,
  gps_sample_packer_if.master bus
);
  localparam int SPW    = WORD_WIDTH / BITS_PER_SAMPLE;
  localparam int FILL_W = (SPW > 1) ? $clog2(SPW) : 1;
  localparam int ACC_W  = (SPW > 1) ? WORD_WIDTH - BITS_PER_SAMPLE : BITS_PER_SAMPLE;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SPW - 1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} hold_state_t;

  hold_state_t           state_q, state_d;
  logic [ACC_W-1:0]      acc_q;
  logic [ACC_W-1:0]      acc_shift;
  logic [FILL_W-1:0]     fill_q;
  logic [WORD_WIDTH-1:0] word_q;
  logic [WORD_WIDTH-1:0] word_new;
  logic                  ovf_q;
  logic [7:0]            cnt_q;
  logic                  complete;
  logic                  transfer;
  logic                  load;
  logic                  drop;

  // The accumulator only holds the first SPW-1 samples; the last one goes straight
  // into the word, so the accumulator never needs clearing between words.
  generate
    if (SPW > 1) begin : g_multi
      assign word_new = {acc_q, bus.sample};
      if (ACC_W > BITS_PER_SAMPLE) begin : g_wide
        assign acc_shift = {acc_q[ACC_W-BITS_PER_SAMPLE-1:0], bus.sample};
      end else begin : g_narrow
        assign acc_shift = bus.sample;
      end
    end else begin : g_single
      assign word_new  = bus.sample;
      assign acc_shift = '0;
    end
  endgenerate

  assign complete = bus.strobe && (fill_q == FILL_LAST);
  assign transfer = (state_q == FULL) && bus.word_ready;
  assign load     = complete && ((state_q == EMPTY) || bus.word_ready);
  assign drop     = complete && !load;

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (complete) state_d = FULL;
      FULL:    if (transfer && !complete) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else if (bus.strobe) begin
      acc_q  <= acc_shift;
      fill_q <= complete ? '0 : fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
    end else if (load) begin
      word_q <= word_new;
    end
  end

  // A drop on the same cycle as a clear wins: the count restarts at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (bus.clear_ovf)        cnt_q <= 8'd1;
      else if (cnt_q != 8'hFF)  cnt_q <= cnt_q + 8'd1;
    end else if (bus.clear_ovf) begin
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end
  end

  assign bus.word       = word_q;
  assign bus.word_valid = (state_q == FULL);
  assign bus.overflow   = ovf_q;
  assign bus.drop_count = cnt_q;
  assign bus.fill       = fill_q;
endmodule
